// File: rtl/rom_fetch_arbiter_pkg.sv
// Shared constants and stage-A payload type for rom_fetch_arbiter.
package rom_arb_pkg;

    localparam int unsigned ADDR_W_DEF     = 32;
    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned DEPTH_LOG2_DEF = 8;
    localparam int unsigned ERR_CNT_W      = 8;

    localparam logic PORT_IFETCH = 1'b0;
    localparam logic PORT_LOAD   = 1'b1;

    typedef struct packed {
        logic                  valid;
        logic                  owner;
        logic [ADDR_W_DEF-1:0] addr;
    } stage_a_t;

endpackage

// File: rtl/rom_fetch_arbiter_if.sv
// Requester/ROM bus bundle for rom_fetch_arbiter.
// Error outputs exist only when ROM_FETCH_ARBITER_ADDR_CHECK_EN is defined.
interface rom_fetch_arbiter_if
    import rom_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic              req0_i;
    logic [ADDR_W-1:0] addr0_i;
    logic              gnt0_o;
    logic              rvalid0_o;
    logic [DATA_W-1:0] rdata0_o;

    logic              req1_i;
    logic [ADDR_W-1:0] addr1_i;
    logic              gnt1_o;
    logic              rvalid1_o;
    logic [DATA_W-1:0] rdata1_o;

    logic [ADDR_W-1:0] rom_addr_o;
    logic [DATA_W-1:0] rom_data_i;

`ifdef ROM_FETCH_ARBITER_ADDR_CHECK_EN
    logic                 err0_o;
    logic                 err1_o;
    logic [ERR_CNT_W-1:0] err_cnt_o;

    modport master (
        output req0_i, addr0_i, req1_i, addr1_i, rom_data_i,
        input  gnt0_o, rvalid0_o, rdata0_o, gnt1_o, rvalid1_o, rdata1_o,
        input  rom_addr_o, err0_o, err1_o, err_cnt_o
    );
    modport slave (
        input  req0_i, addr0_i, req1_i, addr1_i, rom_data_i,
        output gnt0_o, rvalid0_o, rdata0_o, gnt1_o, rvalid1_o, rdata1_o,
        output rom_addr_o, err0_o, err1_o, err_cnt_o
    );
`else
    modport master (
        output req0_i, addr0_i, req1_i, addr1_i, rom_data_i,
        input  gnt0_o, rvalid0_o, rdata0_o, gnt1_o, rvalid1_o, rdata1_o,
        input  rom_addr_o
    );
    modport slave (
        input  req0_i, addr0_i, req1_i, addr1_i, rom_data_i,
        output gnt0_o, rvalid0_o, rdata0_o, gnt1_o, rvalid1_o, rdata1_o,
        output rom_addr_o
    );
`endif

endinterface

// File: rtl/rom_fetch_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the pointer flips only when both ports contend.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        unique case (req)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
                gnt   = ptr_q ? 2'b10 : 2'b01;
                ptr_d = ~ptr_q;
            end
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= 1'b0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/rom_fetch_arbiter.sv
// Two-port round-robin front end for a shared combinational ROM, 2-cycle read latency.
// ROM_FETCH_ARBITER_ADDR_CHECK_EN adds misalignment/range error flags and a saturating counter.
module rom_fetch_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input logic               clk,
    input logic               rst,
    rom_fetch_arbiter_if.slave bus
);
    localparam int unsigned HI_LSB = DEPTH_LOG2 + 2;
    localparam bit          CFG_OK = (HI_LSB <= ADDR_W);

    logic [1:0] req;
    logic [1:0] gnt;

    // Requests are masked during reset so no grant is visible while rst is high.
    assign req = {bus.req1_i, bus.req0_i} & {2{~rst}};

    rr_arb2 u_rr_arb2 (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    assign bus.gnt0_o = gnt[0];
    assign bus.gnt1_o = gnt[1];

    stage_a_t sa_q;
    stage_a_t sa_d;

    always_comb begin
        sa_d       = sa_q;
        sa_d.valid = 1'b0;
        if (gnt[0]) begin
            sa_d.valid = 1'b1;
            sa_d.owner = PORT_IFETCH;
            sa_d.addr  = ADDR_W_DEF'(bus.addr0_i);
        end else if (gnt[1]) begin
            sa_d.valid = 1'b1;
            sa_d.owner = PORT_LOAD;
            sa_d.addr  = ADDR_W_DEF'(bus.addr1_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sa_q <= '0;
        else     sa_q <= sa_d;
    end

    assign bus.rom_addr_o = ADDR_W'(sa_q.addr);

    logic              take0;
    logic              take1;
    logic [DATA_W-1:0] word;

    assign take0 = sa_q.valid && (sa_q.owner == PORT_IFETCH);
    assign take1 = sa_q.valid && (sa_q.owner == PORT_LOAD);

`ifdef ROM_FETCH_ARBITER_ADDR_CHECK_EN
    logic                 addr_bad;
    logic                 err0_q;
    logic                 err1_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    assign addr_bad = (sa_q.addr[1:0] != 2'b00) || ((sa_q.addr >> HI_LSB) != '0);
    assign word     = addr_bad ? '0 : bus.rom_data_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err0_q <= take0 && addr_bad;
            err1_q <= take1 && addr_bad;
            if (sa_q.valid && addr_bad && (err_cnt_q != {ERR_CNT_W{1'b1}}))
                err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

    assign bus.err0_o    = err0_q;
    assign bus.err1_o    = err1_q;
    assign bus.err_cnt_o = err_cnt_q;
`else
    assign word = bus.rom_data_i;
`endif

    logic              rvalid0_q;
    logic              rvalid1_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    // Stage B: steer the ROM word to the owner; the other port's data holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= take0;
            rvalid1_q <= take1;
            if (take0) rdata0_q <= word;
            if (take1) rdata1_q <= word;
        end
    end

    assign bus.rvalid0_o = rvalid0_q;
    assign bus.rvalid1_o = rvalid1_q;
    assign bus.rdata0_o  = rdata0_q;
    assign bus.rdata1_o  = rdata1_q;

    a_one_hot_gnt: assert property (@(posedge clk) disable iff (rst) !(gnt[0] && gnt[1]) && CFG_OK);

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Self-checking bench for rom_fetch_arbiter: queue-based response model plus directed literal checks.
// Compile with ROM_FETCH_ARBITER_ADDR_CHECK_EN defined to cover the address-check build.
module tb_rom_fetch_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rom_fetch_arbiter_if bus ();

    rom_fetch_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [256];
    assign bus.rom_data_i = mem[bus.rom_addr_o[9:2]];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        bit          port;
        logic [31:0] data;
        bit          err;
    } resp_t;

    resp_t       q[$];
    bit          favour  = 1'b0;
    logic [31:0] exp_rd0 = '0;
    logic [31:0] exp_rd1 = '0;
    logic [31:0] exp_ra  = '0;
    int          exp_cnt = 0;

    function automatic bit addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:10] != '0);
    endfunction

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [7:0] idx;
        idx = a[9:2];
        return mem[idx];
    endfunction

    always @(negedge clk) begin
        bit          rv0, rv1, er0, er1, g0, g1;
        logic [31:0] a;
        rv0 = 0; rv1 = 0; er0 = 0; er1 = 0;
        if (rst) begin
            q.delete();
            favour  = 1'b0;
            exp_rd0 = '0;
            exp_rd1 = '0;
            exp_ra  = '0;
            exp_cnt = 0;
        end else if (q.size() > 0 && q[0].due == cyc) begin
            resp_t e;
            e = q.pop_front();
            if (e.port) begin rv1 = 1; er1 = e.err; exp_rd1 = e.data; end
            else        begin rv0 = 1; er0 = e.err; exp_rd0 = e.data; end
            if (e.err && exp_cnt < 255) exp_cnt++;
        end
        check("rvalid0", 32'(bus.rvalid0_o), 32'(rv0));
        check("rvalid1", 32'(bus.rvalid1_o), 32'(rv1));
        check("rdata0", bus.rdata0_o, exp_rd0);
        check("rdata1", bus.rdata1_o, exp_rd1);
        check("rom_addr", bus.rom_addr_o, exp_ra);
`ifdef ROM_FETCH_ARBITER_ADDR_CHECK_EN
        check("err0", 32'(bus.err0_o), 32'(er0));
        check("err1", 32'(bus.err1_o), 32'(er1));
        check("err_cnt", 32'(bus.err_cnt_o), 32'(exp_cnt));
`endif
        g0 = 0; g1 = 0;
        if (!rst) begin
            if (bus.req0_i && bus.req1_i) begin
                if (favour) g1 = 1; else g0 = 1;
                favour = ~favour;
            end else begin
                g0 = bus.req0_i;
                g1 = bus.req1_i;
            end
        end
        check("gnt0", 32'(bus.gnt0_o), 32'(g0));
        check("gnt1", 32'(bus.gnt1_o), 32'(g1));
        if (g0 || g1) begin
            resp_t n;
            a      = g1 ? bus.addr1_i : bus.addr0_i;
            n.due  = cyc + 2;
            n.port = g1;
`ifdef ROM_FETCH_ARBITER_ADDR_CHECK_EN
            n.err  = addr_bad(a);
            n.data = n.err ? 32'h0 : rom_word(a);
`else
            n.err  = 1'b0;
            n.data = rom_word(a);
`endif
            q.push_back(n);
            exp_ra = a;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req0_i = 1'b0;
        bus.req1_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int          nrv;
        logic [5:0]  pat;

        for (int i = 0; i < 256; i++) mem[i] = 32'(i + 1);
        bus.req0_i  = 1'b0;
        bus.req1_i  = 1'b0;
        bus.addr0_i = '0;
        bus.addr1_i = '0;

        // reset state
        tick();
        check("reset_rvalid0", 32'(bus.rvalid0_o), 32'h0);
        check("reset_rdata0", bus.rdata0_o, 32'h0);
        check("reset_rom_addr", bus.rom_addr_o, 32'h0);
        do_reset();

        // single request on port 0
        tick();
        bus.req0_i = 1'b1; bus.addr0_i = 32'h8;
        #2 check("t1_gnt0", 32'(bus.gnt0_o), 32'h1);
        tick(); bus.req0_i = 1'b0;
        tick();
        #2 check("t1_rvalid0", 32'(bus.rvalid0_o), 32'h1);
        check("t1_rdata0", bus.rdata0_o, 32'h3);
        check("t1_rvalid1", 32'(bus.rvalid1_o), 32'h0);
        tick(); tick();

        // contention right after reset: port 0 first
        do_reset();
        bus.req0_i = 1'b1; bus.addr0_i = 32'h0;
        bus.req1_i = 1'b1; bus.addr1_i = 32'h4;
        #2 check("t2_gnt0", 32'(bus.gnt0_o), 32'h1);
        check("t2_gnt1_wait", 32'(bus.gnt1_o), 32'h0);
        tick(); bus.req0_i = 1'b0;
        #2 check("t2_gnt1", 32'(bus.gnt1_o), 32'h1);
        tick(); bus.req1_i = 1'b0;
        #2 check("t2_rdata0", bus.rdata0_o, 32'h1);
        tick();
        #2 check("t2_rdata1", bus.rdata1_o, 32'h2);
        check("t2_rvalid1", 32'(bus.rvalid1_o), 32'h1);
        tick();

        // sustained contention for 6 cycles
        do_reset();
        pat = '0;
        nrv = 0;
        for (int k = 0; k < 8; k++) begin
            bus.req0_i  = (k < 6);
            bus.req1_i  = (k < 6);
            bus.addr0_i = 32'h40 + 32'(4 * ((k + 1) / 2));
            bus.addr1_i = 32'h80 + 32'(4 * (k / 2));
            #2;
            if (k < 6) pat[k] = bus.gnt1_o;
            if (bus.rvalid0_o || bus.rvalid1_o) nrv++;
            tick();
        end
        bus.req0_i = 1'b0;
        bus.req1_i = 1'b0;
        check("t3_gnt_pattern", 32'(pat), 32'h2A);
        check("t3_rvalid_count", 32'(nrv), 32'd6);
        check("t3_last_rdata1", bus.rdata1_o, 32'h23);

        // async reset between grant and response
        do_reset();
        bus.req0_i = 1'b1; bus.addr0_i = 32'h10;
        #2 check("t4_gnt0", 32'(bus.gnt0_o), 32'h1);
        tick();
        bus.req0_i = 1'b0;
        check("t4_rom_addr", bus.rom_addr_o, 32'h10);
        rst = 1'b1;
        #1 check("t4_rst_rom_addr", bus.rom_addr_o, 32'h0);
        check("t4_rst_rvalid0", 32'(bus.rvalid0_o), 32'h0);
        tick();
        rst = 1'b0;
        nrv = 0;
        for (int k = 0; k < 3; k++) begin
            #2 if (bus.rvalid0_o || bus.rvalid1_o) nrv++;
            tick();
        end
        check("t4_no_stale_rvalid", 32'(nrv), 32'h0);
        bus.req0_i = 1'b1; bus.addr0_i = 32'h14;
        tick(); bus.req0_i = 1'b0;
        tick();
        #2 check("t4_after_rvalid0", 32'(bus.rvalid0_o), 32'h1);
        check("t4_after_rdata0", bus.rdata0_o, 32'h6);
        tick();

        // address wrap and misalignment
        do_reset();
        bus.req0_i = 1'b1; bus.addr0_i = 32'h404;
        tick();
        bus.req0_i = 1'b0;
        bus.req1_i = 1'b1; bus.addr1_i = 32'h6;
        tick();
        bus.req1_i = 1'b0;
        #2 check("t5_wrap_rvalid0", 32'(bus.rvalid0_o), 32'h1);
`ifdef ROM_FETCH_ARBITER_ADDR_CHECK_EN
        check("t5_wrap_rdata0", bus.rdata0_o, 32'h0);
        check("t5_wrap_err0", 32'(bus.err0_o), 32'h1);
        check("t5_wrap_cnt", 32'(bus.err_cnt_o), 32'h1);
`else
        check("t5_wrap_rdata0", bus.rdata0_o, 32'h2);
`endif
        tick();
        #2 check("t5_mis_rvalid1", 32'(bus.rvalid1_o), 32'h1);
`ifdef ROM_FETCH_ARBITER_ADDR_CHECK_EN
        check("t5_mis_rdata1", bus.rdata1_o, 32'h0);
        check("t5_mis_err1", 32'(bus.err1_o), 32'h1);
        check("t5_mis_cnt", 32'(bus.err_cnt_o), 32'h2);
`else
        check("t5_mis_rdata1", bus.rdata1_o, 32'h2);
`endif
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_fetch_arbiter.md
Name: rom_fetch_arbiter

Overview:
- Shares one combinational 256x32 instruction ROM between two requesters: port 0 (instruction fetch) and port 1 (data load / debug read).
- Round-robin arbitration with a 2-stage pipeline: grant, then ROM address register, then data register.
- Sits between the core's fetch/load units and the ROM; drives the ROM byte address and captures the ROM word.

Parameters:
- ADDR_W, 32, byte-address width of requester and ROM address buses.
- DATA_W, 32, ROM word width.
- DEPTH_LOG2, 8, log2 of ROM words; used for range checking.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req0_i  in  1  port 0 request; held high with stable addr0_i until gnt0_o.
- addr0_i  in  ADDR_W  port 0 byte address.
- gnt0_o  out  1  port 0 request accepted this cycle (combinational).
- rvalid0_o  out  1  port 0 read data valid, one-cycle pulse.
- rdata0_o  out  DATA_W  port 0 read data.
- req1_i, addr1_i, gnt1_o, rvalid1_o, rdata1_o: same as port 0, for port 1.
- rom_addr_o  out  ADDR_W  registered byte address to the ROM.
- rom_data_i  in  DATA_W  combinational ROM word for rom_addr_o.

Behaviour:
- Reset (async, rst=1): all gnt, rvalid and rdata outputs = 0; rom_addr_o = 0; stage-B valid = 0; round-robin pointer = port 0; error state cleared.
- Arbitration in cycle N:
  - Exactly one of gnt0_o/gnt1_o when any request is present; never both.
  - Single requester: granted immediately.
  - Both requesting: the port named by rr_ptr wins; rr_ptr then flips to the other port.
  - rr_ptr updates only on a contested grant.
- Stage A register (end of N, on any grant):
  - addr_q <= granted address.
  - owner_q <= granted port.
  - vA <= 1; otherwise vA <= 0.
  - rom_addr_o = addr_q; it holds its last value when vA = 0.
- Stage B register (end of N+1, when vA = 1):
  - rdata of the owner port <= rom_data_i.
  - rvalid of the owner port pulses high in cycle N+2.
  - The other port's rdata holds its value.
- Timing:
  - Fixed latency of 2 cycles from grant to rvalid.
  - Throughput of 1 grant per cycle.
  - No backpressure: responses are unconditional.
  - At most 2 accesses in flight.
- Ordering: responses return in grant order. Each port sees in-order responses.
- ROM indexing: the ROM uses addr[DEPTH_LOG2+1:2]. addr[1:0] are ignored and upper bits are ignored, so addresses wrap modulo 1 KiB.
- Reset mid-operation: in-flight stage A/B contents are discarded; no rvalid is emitted after reset deasserts.
- Request dropped before grant: legal, nothing issued.
- gnt is only asserted while the corresponding req is high.

Optional Feature:
- Macro: ROM_FETCH_ARBITER_ADDR_CHECK_EN.
- When defined:
  - Adds outputs err0_o and err1_o, each 1 bit.
  - errN_o pulses together with rvalidN_o if the granted address had addr[1:0] != 0 or any bit above DEPTH_LOG2+1 set.
  - rdata is forced to 0 for that response.
  - Adds a sticky 8-bit saturating err_cnt_o, cleared only by rst.
- When undefined: no error ports or counter exist; all addresses are accepted with the wrap behaviour above.

Decomposition:
- Package rom_arb_pkg holds:
  - Port-ID constants PORT_IFETCH=0 and PORT_LOAD=1.
  - Default widths.
  - A stage-A struct/typedef {valid, owner, addr}.
- One sub-module: rr_arb2, the 2-way round-robin arbiter (req[1:0], ptr register, gnt[1:0]). The pipeline registers and response demux live in the top module.

Test Plan:
- Reset then single request: ROM preloaded with mem[i]=i+1; req0 with addr0=0x8 in cycle 1 -> gnt0 in cycle 1, rvalid0 in cycle 3 with rdata0=0x3, rvalid1 never asserts.
- Contention: req0 and req1 both held, addr0=0x0 and addr1=0x4 -> gnt0 in cycle 1, gnt1 in cycle 2 (rr after reset favours port 0), rdata0=0x1 and rdata1=0x2 on consecutive cycles.
- Sustained both-request for 6 cycles -> grants alternate 0,1,0,1,0,1; 6 rvalid pulses back-to-back, each with the correct owner.
- Async reset asserted between a grant and its rvalid -> outputs clear immediately; no rvalid after reset release; next request completes with latency 2.
- Wrap: addr0=0x404 -> rdata0 equals mem[1]=0x2. With ROM_FETCH_ARBITER_ADDR_CHECK_EN defined: err0 pulses, rdata0=0, err_cnt_o=1.
- Misaligned addr1=0x6 with the macro defined -> err1 pulses with rvalid1; err_cnt_o increments. With the macro undefined -> rdata1=mem[1]=0x2.
